ee_rd_tx_module: RTL and testbench

Serial read-data transmitter for the EEPROM's two-wire slave interface, the transmit counterpart of the address/command receiver. After the receiver decodes a read command and acknowledges the device address, this block serializes EEPROM bytes MSB-first onto the SDA pull-down (`padout`) and samples the master's ACK/NACK. It requests each next byte through a valid/ready handshake and pulses an address-increment strobe. It runs entirely on the digital core clock, oversampling SCL and SDA.

---
 rtl/ee_tx_pkg.sv | 14 +
 rtl/ee_rd_tx_module_pad_sync_edge.sv | 67 ++++++
 rtl/ee_rd_tx_module.sv | 148 ++++++++++++++
 tb/tb_ee_rd_tx_module.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ee_tx_pkg.sv
// Shared types and constants for the EEPROM two-wire read-data transmitter.
package ee_tx_pkg;

  localparam int          TX_BYTE_BITS = 8;
  localparam logic [7:0]  TX_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    ACK   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/ee_rd_tx_module_pad_sync_edge.sv
// Pad synchronizer with registered edge detect; TX_GLITCH_FILT_EN adds a
// 3-sample majority filter after the synchronizer.
module pad_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   clean;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{RST_VAL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef TX_GLITCH_FILT_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Registering the vote costs the second clock of added latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= {2{RST_VAL}};
      filt_q <= RST_VAL;
    end else begin
      hist_q <= {hist_q[0], synced};
      filt_q <= (synced & hist_q[0]) | (synced & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign clean = filt_q;
`else
  assign clean = synced;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= clean;
      rise_q <= clean & ~prev_q;
      fall_q <= ~clean & prev_q;
    end
  end

  assign level_o = clean;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ee_rd_tx_module.sv
// EEPROM read-data serializer: shifts bytes MSB-first onto the SDA pull-down
// and samples master ACK/NACK. Optional macro: TX_GLITCH_FILT_EN.
module ee_rd_tx_module
  import ee_tx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  input  logic                  tx_start,
  input  logic                  tx_abort,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  padout,
  output logic                  tx_busy,
  output logic                  byte_done,
  output logic                  master_ack,
  output logic                  addr_inc,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(TX_BYTE_BITS);

  logic                  scl_rise;
  logic                  scl_fall;
  logic                  sda_lvl;

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  padout_q;
  logic                  tx_ready_q;
  logic                  byte_done_q;
  logic                  addr_inc_q;
  logic                  master_ack_q;
  logic                  underrun_q;
  logic                  ack_seen_q;

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (scl_in),
    .level_o (),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (sda_in),
    .level_o (sda_lvl),
    .rise_o  (),
    .fall_o  ()
  );

  always_ff @(posedge clk) begin
    // NOTE: the shift register is cleared too, so a reset mid-byte cannot leak
    // stale data into the next transfer.
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      padout_q     <= 1'b0;
      tx_ready_q   <= 1'b0;
      byte_done_q  <= 1'b0;
      addr_inc_q   <= 1'b0;
      master_ack_q <= 1'b0;
      underrun_q   <= 1'b0;
      ack_seen_q   <= 1'b0;
    end else begin
      tx_ready_q  <= 1'b0;
      byte_done_q <= 1'b0;
      addr_inc_q  <= 1'b0;
      if (tx_abort) begin
        state_q    <= IDLE;
        padout_q   <= 1'b0;
        ack_seen_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            padout_q <= 1'b0;
            if (tx_start) begin
              state_q    <= LOAD;
              tx_ready_q <= 1'b1;
              underrun_q <= 1'b0;
            end
          end
          LOAD: begin
            if (tx_valid) begin
              shift_q  <= tx_data;
              padout_q <= ~tx_data[DATA_WIDTH-1];
            end else begin
              shift_q    <= TX_IDLE_BYTE;
              padout_q   <= ~TX_IDLE_BYTE[DATA_WIDTH-1];
              underrun_q <= 1'b1;
            end
            cnt_q   <= CNT_W'(TX_BYTE_BITS - 1);
            state_q <= SHIFT;
          end
          SHIFT: begin
            if (scl_fall) begin
              if (cnt_q == '0) begin
                padout_q   <= 1'b0;
                ack_seen_q <= 1'b0;
                state_q    <= ACK;
              end else begin
                shift_q  <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                cnt_q    <= cnt_q - 1'b1;
                padout_q <= ~shift_q[DATA_WIDTH-2];
              end
            end
          end
          ACK: begin
            // Only a fall that follows the sampled rise closes the ACK bit.
            if (scl_rise && !ack_seen_q) begin
              master_ack_q <= ~sda_lvl;
              byte_done_q  <= 1'b1;
              addr_inc_q   <= 1'b1;
              ack_seen_q   <= 1'b1;
            end else if (scl_fall && ack_seen_q) begin
              if (master_ack_q) begin
                state_q    <= LOAD;
                tx_ready_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready   = tx_ready_q;
  assign padout     = padout_q;
  assign tx_busy    = (state_q != IDLE);
  assign byte_done  = byte_done_q;
  assign master_ack = master_ack_q;
  assign addr_inc   = addr_inc_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ee_rd_tx_module.sv
// Scoreboard bench for ee_rd_tx_module: a two-wire master model clocks bytes
// out while expected pad values are queued and popped per bit.
module tb_ee_rd_tx_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_in;
  logic       tx_start;
  logic       tx_abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       padout;
  logic       tx_busy;
  logic       byte_done;
  logic       master_ack;
  logic       addr_inc;
  logic       underrun;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int exp_done = 0;
  int exp_ready = 0;
  bit exp_q[$];

  ee_rd_tx_module dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .tx_start   (tx_start),
    .tx_abort   (tx_abort),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .padout     (padout),
    .tx_busy    (tx_busy),
    .byte_done  (byte_done),
    .master_ack (master_ack),
    .addr_inc   (addr_inc),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Pulse counters read the value held during the cycle that just ended.
  always @(posedge clk) begin
    if (byte_done) done_cnt++;
    if (tx_ready)  ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_bits(input logic [7:0] data, input bit valid);
    for (int i = 7; i >= 0; i--) exp_q.push_back(valid ? ~data[i] : 1'b0);
  endtask

  task automatic start_byte(input logic [7:0] data, input bit valid);
    tx_data  = data;
    tx_valid = valid;
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    exp_ready++;
    check("start_ready", tx_ready, 1);
    check("start_busy", tx_busy, 1);
  endtask

  task automatic shift_bit(input string tag);
    bit e;
    cyc(8);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, padout, e);
    end
    scl_in = 1'b1;
    cyc(8);
    scl_in = 1'b0;
  endtask

  task automatic shift_byte(input string tag);
    for (int i = 0; i < 8; i++) shift_bit(tag);
  endtask

  task automatic ack_bit(input bit ack, input bit nxt_valid, input logic [7:0] nxt_data);
    bit found;
    cyc(8);
    check("ack_release", padout, 0);
    sda_in   = ack ? 1'b0 : 1'b1;
    tx_valid = nxt_valid;
    tx_data  = nxt_data;
    scl_in   = 1'b1;
    found    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (byte_done) begin
        found = 1'b1;
        break;
      end
    end
    check("byte_done_seen", found, 1);
    check("addr_inc", addr_inc, 1);
    check("master_ack", master_ack, ack);
    exp_done++;
    cyc(1);
    check("byte_done_single", byte_done, 0);
    cyc(6);
    scl_in = 1'b0;
    sda_in = 1'b1;
    cyc(4);
    if (ack) begin
      exp_ready++;
      check("next_ready", tx_ready, 1);
      check("next_busy", tx_busy, 1);
    end else begin
      check("nack_busy", tx_busy, 0);
      check("nack_pad", padout, 0);
    end
  endtask

  initial begin
    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
    tx_start = 1'b0; tx_abort = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("rst_pad", padout, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", byte_done, 0);
    check("rst_mack", master_ack, 0);
    check("rst_inc", addr_inc, 0);
    check("rst_under", underrun, 0);

    scl_in = 1'b0;
    cyc(6);

    // 0xA5 acked, followed by 0x3C nacked
    push_bits(8'hA5, 1);
    start_byte(8'hA5, 1);
    shift_byte("a5_bit");
    push_bits(8'h3C, 1);
    ack_bit(1, 1, 8'h3C);
    shift_byte("3c_bit");
    ack_bit(0, 0, 8'h00);

    // Underrun: nothing valid at LOAD, pad stays released
    push_bits(8'h00, 0);
    start_byte(8'h55, 0);
    shift_byte("under_bit");
    check("underrun_set", underrun, 1);
    ack_bit(0, 0, 8'h00);
    check("underrun_sticky", underrun, 1);

    // Next start clears underrun; then reset lands mid-byte
    push_bits(8'h00, 1);
    start_byte(8'h00, 1);
    check("underrun_clr", underrun, 0);
    shift_byte("zero_bit");
    push_bits(8'h81, 1);
    ack_bit(1, 1, 8'h81);
    for (int i = 0; i < 3; i++) shift_bit("pre_rst_bit");
    cyc(6);
    check("pre_rst_pad", padout, 1);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_pad", padout, 0);
    check("mid_rst_ready", tx_ready, 0);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_done", byte_done, 0);
    check("mid_rst_mack", master_ack, 0);
    check("mid_rst_inc", addr_inc, 0);
    check("mid_rst_under", underrun, 0);
    rst = 1'b0;
    exp_q.delete();
    cyc(6);

    // Abort during bit 4
    push_bits(8'h86, 1);
    start_byte(8'h86, 1);
    for (int i = 0; i < 3; i++) shift_bit("abort_pre_bit");
    cyc(8);
    check("abort_bit4_pad", padout, exp_q.pop_front());
    tx_abort = 1'b1;
    cyc(1);
    tx_abort = 1'b0;
    check("abort_busy", tx_busy, 0);
    check("abort_pad", padout, 0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      scl_in = 1'b1; cyc(8);
      scl_in = 1'b0; cyc(8);
    end
    check("abort_idle", tx_busy, 0);
    check("abort_no_done", done_cnt, exp_done);

    // Start and abort together
    tx_start = 1'b1; tx_abort = 1'b1;
    cyc(1);
    tx_start = 1'b0; tx_abort = 1'b0;
    check("both_busy", tx_busy, 0);
    check("both_ready", tx_ready, 0);
    cyc(4);
    check("both_busy_late", tx_busy, 0);
    check("ready_count", ready_cnt, exp_ready);
    check("done_count", done_cnt, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
